// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - ordered multi-phase controller with sticky dones, watchdog, abort and frame counter
module phase_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter int PHASE_W    = 2,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16,
  parameter int CONTINUOUS = 0,
  parameter int FRAME_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NUM_PHASES-1:0] done_i,
  output logic [NUM_PHASES-1:0] phase_start_o,
  output logic [NUM_PHASES-1:0] phase_en_o,
  output logic [PHASE_W-1:0]    phase_o,
  output logic [1:0]            status_o,
  output logic [NUM_PHASES-1:0] done_seen_o,
  output logic [PHASE_W-1:0]    error_phase_o,
  output logic [FRAME_W-1:0]    frame_count_o
);

  // Encodings double as the status code.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_ERROR  = 2'b10,
    S_FINISH = 2'b11
  } state_e;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0]   WD_LAST    = CNT_W'(TIMEOUT - 1);
  localparam bit                 WD_EN      = (TIMEOUT != 0);
  localparam bit                 CONT_EN    = (CONTINUOUS != 0);

  state_e                  state_q, state_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [CNT_W-1:0]        wdog_q, wdog_d;
  logic [NUM_PHASES-1:0]   done_seen_q, done_seen_d;
  logic [NUM_PHASES-1:0]   phase_start_q, phase_start_d;
  logic [NUM_PHASES-1:0]   phase_en_q, phase_en_d;
  logic [PHASE_W-1:0]      error_phase_q, error_phase_d;
  logic [FRAME_W-1:0]      frame_q, frame_d;

  logic [NUM_PHASES-1:0]   cur_sel;
  logic [NUM_PHASES-1:0]   next_sel;
  logic [NUM_PHASES-1:0]   next_therm;
  logic                    phase_complete;
  logic                    enter_run0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      wdog_q        <= '0;
      done_seen_q   <= '0;
      phase_start_q <= '0;
      phase_en_q    <= '0;
      error_phase_q <= '0;
      frame_q       <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      wdog_q        <= wdog_d;
      done_seen_q   <= done_seen_d;
      phase_start_q <= phase_start_d;
      phase_en_q    <= phase_en_d;
      error_phase_q <= error_phase_d;
      frame_q       <= frame_d;
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_PHASES; j++) begin
      cur_sel[j] = (PHASE_W'(j) == phase_q);
    end
  end

  // A done counts whether it arrives now or was latched earlier in the frame.
  assign phase_complete = |((done_i | done_seen_q) & cur_sel);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    wdog_d        = wdog_q;
    done_seen_d   = done_seen_q;
    error_phase_d = error_phase_q;
    frame_d       = frame_q;
    enter_run0    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) enter_run0 = 1'b1;
      end
      S_RUN: begin
        done_seen_d = done_seen_q | done_i;
        wdog_d      = wdog_q + 1'b1;
        if (phase_complete) begin
          wdog_d = '0;
          if (phase_q == LAST_PHASE) begin
            state_d = S_FINISH;
            frame_d = frame_q + 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end else if (WD_EN && (wdog_q == WD_LAST)) begin
          state_d       = S_ERROR;
          error_phase_d = phase_q;
          wdog_d        = '0;
        end
      end
      S_FINISH: begin
        if (CONT_EN || start_i) enter_run0 = 1'b1;
      end
      S_ERROR: begin
        if (start_i) enter_run0 = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fresh frame forgets dones from the previous one, including this cycle's.
    if (enter_run0) begin
      state_d     = S_RUN;
      phase_d     = '0;
      wdog_d      = '0;
      done_seen_d = '0;
    end

    if (abort_i) begin
      state_d       = S_IDLE;
      phase_d       = '0;
      wdog_d        = '0;
      done_seen_d   = '0;
      error_phase_d = error_phase_q;
      frame_d       = frame_q;
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_PHASES; j++) begin
      next_sel[j]   = (PHASE_W'(j) == phase_d);
      next_therm[j] = (PHASE_W'(j) <= phase_d);
    end
  end

  always_comb begin
    phase_start_d = '0;
    phase_en_d    = '0;
    if (state_d == S_RUN) begin
      phase_en_d = next_therm;
      if ((state_q != S_RUN) || (phase_d != phase_q)) phase_start_d = next_sel;
    end else if (state_d == S_FINISH) begin
      phase_en_d = '1;
    end
  end

  assign phase_start_o = phase_start_q;
  assign phase_en_o    = phase_en_q;
  assign phase_o       = phase_q;
  assign status_o      = state_q;
  assign done_seen_o   = done_seen_q;
  assign error_phase_o = error_phase_q;
  assign frame_count_o = frame_q;

endmodule
